// File: rtl/psk_phase_tracker.sv
// psk_phase_tracker
// Reduces each correlator match mask to a carrier phase index. A lock FSM
// with hysteresis decides when that phase is trusted. While locked, the block
// recovers differential PSK bits from roughly 180-degree phase jumps.
// Two-stage pipeline: classify on the strobe cycle, then track in the next cycle.

module psk_phase_tracker #(
   parameter int LOCK_CNT   = 4,
   parameter int UNLOCK_CNT = 3,
   parameter int MAX_RUN    = 3
) (
   input  logic       clk,
   input  logic       rst_in,
   input  logic [7:0] value,
   input  logic       stb,
   output logic [2:0] phase,
   output logic       locked,
   output logic       bit_out,
   output logic       bit_vld,
   output logic [7:0] err_cnt
);

   typedef enum logic [1:0] {CLS_EMPTY, CLS_AMBIG, CLS_VALID} cls_e;
   typedef enum logic {ST_SEARCH, ST_LOCKED} state_e;

   state_e     state_q, state_d;
   logic       s1_vld_q, s1_vld_d;
   cls_e       s1_cls_q, s1_cls_d;
   logic [2:0] s1_ph_q, s1_ph_d;
   logic [2:0] phase_q, phase_d;
   logic       ref_valid_q, ref_valid_d;
   logic [3:0] good_cnt_q, good_cnt_d;
   logic [3:0] bad_cnt_q, bad_cnt_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       bit_out_q, bit_out_d;
   logic       bit_vld_q, bit_vld_d;

   logic [3:0] run_cnt;
   logic [3:0] run_len;
   logic [2:0] run_start;
   logic [2:0] ph_diff;
   logic       win_valid;
   logic       consistent;
   logic       flip;
   logic [3:0] good_step;
   logic [3:0] bad_step;

   // Stage 1: find the circular run of set bits and reduce it to a phase index
   always_comb begin
      run_cnt   = '0;
      run_len   = '0;
      run_start = '0;
      for (int j = 0; j < 8; j++) begin
         if (value[j] && !value[(j + 7) % 8]) begin
            run_cnt   = run_cnt + 4'd1;
            run_start = 3'(j);
         end
         if (value[j]) begin
            run_len = run_len + 4'd1;
         end
      end
      s1_vld_d = stb;
      s1_ph_d  = run_start + 3'((run_len - 4'd1) >> 1);
      if (value == 8'h00) begin
         s1_cls_d = CLS_EMPTY;
      end else if (value == 8'hFF || run_cnt != 4'd1 || run_len > 4'(MAX_RUN)) begin
         s1_cls_d = CLS_AMBIG;
      end else begin
         s1_cls_d = CLS_VALID;
      end
   end

   // Stage 2 window evaluation: phase step against the reference and counter steps
   always_comb begin
      ph_diff    = s1_ph_q - phase_q;
      win_valid  = (s1_cls_q == CLS_VALID);
      consistent = s1_vld_q && win_valid && ref_valid_q &&
                   (ph_diff != 3'd2) && (ph_diff != 3'd6);
      flip       = consistent && (ph_diff >= 3'd3) && (ph_diff <= 3'd5);
      good_step  = consistent ? (good_cnt_q + 4'd1) : 4'd1;
      bad_step   = bad_cnt_q + 4'd1;
   end

   // Lock FSM next-state logic, advanced only by stage-2 windows
   always_comb begin
      state_d = state_q;
      if (s1_vld_q) begin
         case (state_q)
            ST_SEARCH: if (win_valid && good_step >= 4'(LOCK_CNT)) state_d = ST_LOCKED;
            ST_LOCKED: if (!consistent && bad_step >= 4'(UNLOCK_CNT)) state_d = ST_SEARCH;
            default:   state_d = ST_SEARCH;
         endcase
      end
   end

   // Tracking datapath: reference phase, hysteresis counters, error count and bit output
   always_comb begin
      phase_d     = phase_q;
      ref_valid_d = ref_valid_q;
      good_cnt_d  = good_cnt_q;
      bad_cnt_d   = bad_cnt_q;
      err_cnt_d   = err_cnt_q;
      bit_out_d   = bit_out_q;
      bit_vld_d   = 1'b0;
      if (s1_vld_q) begin
         if (state_q == ST_SEARCH) begin
            if (!win_valid) begin
               good_cnt_d  = '0;
               ref_valid_d = 1'b0;
            end else begin
               phase_d     = s1_ph_q;
               ref_valid_d = 1'b1;
               good_cnt_d  = good_step;
               if (state_d == ST_LOCKED) begin
                  bad_cnt_d = '0;
               end
            end
         end else begin
            if (consistent) begin
               phase_d   = s1_ph_q;
               bad_cnt_d = '0;
               bit_vld_d = 1'b1;
               bit_out_d = flip;
            end else begin
               if (err_cnt_q != 8'hFF) begin
                  err_cnt_d = err_cnt_q + 8'd1;
               end
               bad_cnt_d = bad_step;
               if (state_d == ST_SEARCH) begin
                  good_cnt_d  = '0;
                  ref_valid_d = 1'b0;
                  bad_cnt_d   = '0;
               end
            end
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst_in) begin
         state_q <= ST_SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Pipeline and tracking registers; reset also discards any in-flight window
   always_ff @(posedge clk) begin
      if (rst_in) begin
         s1_vld_q    <= 1'b0;
         s1_cls_q    <= CLS_EMPTY;
         s1_ph_q     <= '0;
         phase_q     <= '0;
         ref_valid_q <= 1'b0;
         good_cnt_q  <= '0;
         bad_cnt_q   <= '0;
         err_cnt_q   <= '0;
         bit_out_q   <= 1'b0;
         bit_vld_q   <= 1'b0;
      end else begin
         s1_vld_q    <= s1_vld_d;
         s1_cls_q    <= s1_cls_d;
         s1_ph_q     <= s1_ph_d;
         phase_q     <= phase_d;
         ref_valid_q <= ref_valid_d;
         good_cnt_q  <= good_cnt_d;
         bad_cnt_q   <= bad_cnt_d;
         err_cnt_q   <= err_cnt_d;
         bit_out_q   <= bit_out_d;
         bit_vld_q   <= bit_vld_d;
      end
   end

   // Output decode: locked mirrors the state register
   always_comb begin
      locked  = (state_q == ST_LOCKED);
      phase   = phase_q;
      bit_out = bit_out_q;
      bit_vld = bit_vld_q;
      err_cnt = err_cnt_q;
   end

endmodule
